// File: rtl/mul_xbit_shift.sv
// mul_xbit_shift: multi-cycle unsigned shift-and-add multiplier with valid/ready handshakes.
// Optional early termination when MUL_XBIT_SHIFT_EARLY_EN is defined.
module adder_xbit_ahead #(
    parameter int DATA_WIDTH = 4
) (
    input  logic [DATA_WIDTH-1:0] i_num_a,
    input  logic [DATA_WIDTH-1:0] i_num_b,
    input  logic                  i_cry,
    output logic [DATA_WIDTH-1:0] o_res,
    output logic                  o_cry
);
    logic [DATA_WIDTH-1:0] g, p;
    logic                  cy;
    assign g = i_num_a & i_num_b;
    assign p = i_num_a ^ i_num_b;
    always_comb begin
        cy = i_cry;
        o_res = '0;
        for (int i = 0; i < DATA_WIDTH; i++) begin
            o_res[i] = p[i] ^ cy;
            cy = g[i] | (p[i] & cy);
        end
        o_cry = cy;
    end
endmodule

module mul_xbit_shift #(
    parameter int DATA_WIDTH = 4
) (
    input  logic                    i_clk,
    input  logic                    i_rst,
    input  logic                    i_valid,
    output logic                    o_ready,
    input  logic [DATA_WIDTH-1:0]   i_num_a,
    input  logic [DATA_WIDTH-1:0]   i_num_b,
    output logic                    o_valid,
    input  logic                    i_ready,
    output logic [2*DATA_WIDTH-1:0] o_res,
    output logic                    o_busy
);
    localparam int CNT_WIDTH = $clog2(DATA_WIDTH) + 1;
    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
    state_t state, state_nxt;
    logic [DATA_WIDTH-1:0]   hi, lo, mcand, addend, sum;
    logic                    cry, fin;
    logic [CNT_WIDTH-1:0]    cnt;
    logic [2*DATA_WIDTH-1:0] res, res_nxt;
    assign addend = lo[0] ? mcand : '0;
    adder_xbit_ahead #(.DATA_WIDTH(DATA_WIDTH)) u_add (
        .i_num_a(hi),
        .i_num_b(addend),
        .i_cry  (1'b0),
        .o_res  (sum),
        .o_cry  (cry)
    );
`ifdef MUL_XBIT_SHIFT_EARLY_EN
    // lo[cnt-1:0] still holds the unconsumed multiplier bits
    logic early;
    assign early   = (lo & ~({DATA_WIDTH{1'b1}} << cnt)) == '0;
    assign fin     = early || cnt == CNT_WIDTH'(1);
    assign res_nxt = early ? {hi, lo} >> cnt : {cry, sum, lo[DATA_WIDTH-1:1]};
`else
    assign fin     = cnt == CNT_WIDTH'(1);
    assign res_nxt = {cry, sum, lo[DATA_WIDTH-1:1]};
`endif
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) state <= IDLE;
        else       state <= state_nxt;
    end
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    state_nxt = i_valid ? CALC : IDLE;
            CALC:    state_nxt = fin ? DONE : CALC;
            DONE:    state_nxt = i_ready ? IDLE : DONE;
            default: state_nxt = IDLE;
        endcase
    end
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            hi    <= '0;
            lo    <= '0;
            mcand <= '0;
            cnt   <= '0;
            res   <= '0;
        end else if (state == IDLE && i_valid) begin
            hi    <= '0;
            lo    <= i_num_b;
            mcand <= i_num_a;
            cnt   <= CNT_WIDTH'(DATA_WIDTH);
        end else if (state == CALC) begin
            {hi, lo} <= {cry, sum, lo[DATA_WIDTH-1:1]};
            cnt      <= cnt - 1'b1;
            if (fin) res <= res_nxt;
        end
    end
    assign o_ready = state == IDLE;
    assign o_busy  = state == CALC;
    assign o_valid = state == DONE;
    assign o_res   = res;
endmodule

// File: doc/mul_xbit_shift.md
Name: mul_xbit_shift

Overview:
- Multi-cycle unsigned shift-and-add multiplier.
- Instantiates adder_xbit_ahead (same DATA_WIDTH) as its only partial-product adder and consumes that adder's o_res/o_cry every iteration.
- Operands in, product out, each with valid/ready handshakes.
- Sits between the operand-issue logic and the ALU result mux.

Parameters:
- DATA_WIDTH, 4, operand width W; product width is 2W; must be >= 2.
- CNT_WIDTH, $clog2(DATA_WIDTH)+1, width of the internal step counter. Local, derived, not overridable.

Ports:
- i_clk  input  1  clock, rising edge.
- i_rst  input  1  reset, asynchronous, active-high.
- i_valid  input  1  operand pair valid.
- o_ready  output  1  block can accept operands.
- i_num_a  input  W  multiplicand, unsigned.
- i_num_b  input  W  multiplier, unsigned.
- o_valid  output  1  product valid.
- i_ready  input  1  consumer accepts product.
- o_res  output  2W  product a*b.
- o_busy  output  1  high while in CALC.

Behaviour:
- Reset (async assert on i_rst high): state=IDLE, o_ready=1, o_valid=0, o_busy=0, o_res=0. All internal registers (hi, lo, mcand, cnt, cry) cleared. i_rst mid-CALC or mid-DONE aborts; the partial product is discarded, no o_valid.
- FSM IDLE:
  - o_ready=1.
  - On an edge with i_valid=1: load mcand=i_num_a, lo=i_num_b, hi=0, cnt=W; go to CALC.
  - No combinational path from i_valid to o_ready.
- FSM CALC:
  - o_ready=0, o_busy=1.
  - Adder inputs: i_num_a=hi, i_num_b=mcand if lo[0]=1 else 0; i_cry=0.
  - Each edge: {hi,lo} <= {o_cry, o_res, lo[W-1:1]}, i.e. a 2W+1-bit right shift of {cry,sum,lo}; cnt <= cnt-1.
  - When cnt reaches 1 on the current edge: go to DONE, and o_res <= the shifted {hi,lo}.
- FSM DONE:
  - o_valid=1, o_res stable.
  - On an edge with i_ready=1: go to IDLE, o_valid=0.
  - o_res holds its value until the next product is written.
  - i_valid is ignored outside IDLE; upstream must hold its operands.
- Latency:
  - Accept edge to o_valid high: exactly W edges (feature off).
  - Minimum accept-to-accept spacing: W+2 cycles, assuming i_ready held high.
- Arithmetic:
  - The adder carry must be captured into the hi MSB shift-in every step. Max product (2^W-1)^2 must be exact.
  - Width rule: 2W result, no overflow possible.
- Simultaneous events:
  - DONE with i_ready=1 and i_valid=1 on the same edge: the product handshake completes; the new operands are NOT accepted (o_ready=0 in DONE). They are accepted one cycle later in IDLE.

Optional Feature:
- Macro: MUL_XBIT_SHIFT_EARLY_EN
- Defined (early termination): in CALC, if the unconsumed multiplier bits are all zero at an edge, that edge writes o_res <= {hi,lo} >> cnt (barrel shift) and moves to DONE.
  - Latency L = min(W, msb_index(b)+2).
  - For b=0, L = 1.
  - Results must be bit-identical to the feature-off build.
- Undefined: fixed W-cycle latency. No barrel shifter is synthesised.

Test Plan (W=4):
- Reset: assert i_rst mid-CALC (a=4'b1111, b=4'b1111, 2 edges after accept) -> o_valid=0, o_ready=1, o_res=0 immediately. After release, a=3, b=5 -> o_res=8'd15.
- Max operands: a=4'b1111, b=4'b1111 -> o_res=8'd225 (8'b11100001) after exactly 4 edges (feature off). Checks carry capture.
- Sweep: all 256 (a,b) pairs, i_ready=1 -> o_res=a*b every time. Feature off: accept-to-o_valid always 4 edges.
- Back-pressure: a=4'b1100, b=4'b1001, i_ready=0 for 5 cycles -> o_valid stays 1, o_res=8'd108 stable, o_ready=0. Assert i_ready -> IDLE next edge. i_valid held throughout is accepted only once, in IDLE.
- Zero operands: a=0, b=4'b0110 -> o_res=0 after 4 edges. a=4'b0111, b=0 -> o_res=0 after 4 edges (1 edge with MUL_XBIT_SHIFT_EARLY_EN).
- Early termination (macro defined): a=4'b1110, b=4'b0001 -> o_res=8'd14 after 2 edges. b=4'b0100 -> 4 edges. b=4'b1000 -> 4 edges. Results match the feature-off build.
